// File: rtl/state_pkg.sv
// Shared encodings and widths for the state_machine compare responder.
package state_pkg;

  localparam int DATA_W  = 8;
  localparam int STATE_W = 4;
  localparam int CNT_W   = $clog2(DATA_W);

  localparam logic [STATE_W-1:0] RESERVED_CODE = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LOAD  = 2'b01,
    ST_SHIFT = 2'b10,
    ST_DONE  = 2'b11
  } fsm_state_t;

  typedef enum logic [1:0] {
    MODE_EQ = 2'b00,
    MODE_GT = 2'b01,
    MODE_LT = 2'b10,
    MODE_NE = 2'b11
  } cmp_mode_t;

  function automatic logic mode_result(input cmp_mode_t mode, input logic gt, input logic lt);
    logic res;
    case (mode)
      MODE_EQ: res = !gt && !lt;
      MODE_GT: res = gt;
      MODE_LT: res = lt;
      default: res = gt || lt;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/serial_cmp.sv
// MSB-first serial magnitude comparator: the first differing bit pair decides.
module serial_cmp (
  input  logic clk,
  input  logic reset,
  input  logic bit_a,
  input  logic bit_b,
  input  logic clear,
  input  logic enable,
  output logic gt,
  output logic lt
);

  logic gt_reg;
  logic lt_reg;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      gt_reg <= 1'b0;
      lt_reg <= 1'b0;
    end else if (enable && !gt_reg && !lt_reg) begin
      // once decided, lower-order bits no longer matter
      gt_reg <= bit_a & ~bit_b;
      lt_reg <= ~bit_a & bit_b;
    end
  end

  assign gt = gt_reg;
  assign lt = lt_reg;

endmodule

// File: rtl/compare_responder.sv
// Serial 8-bit comparator triggered by state_machine code changes; the low two
// bits of the code select EQ/GT/LT/NE, the answer returns on compare_result.
module compare_responder
  import state_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [STATE_W-1:0] new_state,
  input  logic               hold,
  input  logic               error,
  input  logic [DATA_W-1:0]  operand_a,
  input  logic [DATA_W-1:0]  operand_b,
  output logic               compare_result,
  output logic               cmp_done,
  output logic               busy,
  output logic [7:0]         error_count
);

  fsm_state_t         state_reg;
  fsm_state_t         state_next;
  logic [STATE_W-1:0] prev_state_reg;
  cmp_mode_t          mode_reg;
  logic [DATA_W-1:0]  sh_a_reg;
  logic [DATA_W-1:0]  sh_b_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic               compare_result_reg;
  logic [7:0]         error_count_reg;

  logic trigger;
  logic abort;
  logic step;
  logic bit_a;
  logic bit_b;
  logic cmp_gt;
  logic cmp_lt;
  logic final_gt;
  logic final_lt;

  assign trigger = (new_state != prev_state_reg) && !hold && !error &&
                   (new_state != RESERVED_CODE);
  assign abort   = error && (state_reg != ST_IDLE);
  assign step    = (state_reg == ST_SHIFT) && !hold && !error;
  assign bit_a   = sh_a_reg[DATA_W-1];
  assign bit_b   = sh_b_reg[DATA_W-1];

  serial_cmp u_serial_cmp (
    .clk    (clk),
    .reset  (reset),
    .bit_a  (bit_a),
    .bit_b  (bit_b),
    .clear  (state_reg == ST_LOAD),
    .enable (step),
    .gt     (cmp_gt),
    .lt     (cmp_lt)
  );

  // The last bit is still in flight on the edge entering DONE, so fold it in here.
  assign final_gt = cmp_gt || (!cmp_lt && bit_a && !bit_b);
  assign final_lt = cmp_lt || (!cmp_gt && !bit_a && bit_b);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (trigger) state_next = ST_LOAD;
      ST_LOAD: begin
        if (abort)      state_next = ST_IDLE;
        else if (!hold) state_next = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (abort)                        state_next = ST_IDLE;
        else if (!hold && cnt_reg == '0)  state_next = ST_DONE;
      end
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg          <= ST_IDLE;
      prev_state_reg     <= '0;
      mode_reg           <= MODE_EQ;
      sh_a_reg           <= '0;
      sh_b_reg           <= '0;
      cnt_reg            <= '0;
      compare_result_reg <= 1'b1;
      error_count_reg    <= '0;
    end else begin
      state_reg <= state_next;

      if (state_reg == ST_IDLE && trigger) begin
        prev_state_reg <= new_state;
        mode_reg       <= cmp_mode_t'(new_state[1:0]);
      end

      if (state_reg == ST_LOAD && !hold && !error) begin
        sh_a_reg <= operand_a;
        sh_b_reg <= operand_b;
        cnt_reg  <= CNT_W'(DATA_W - 1);
      end

      if (step) begin
        sh_a_reg <= {sh_a_reg[DATA_W-2:0], 1'b0};
        sh_b_reg <= {sh_b_reg[DATA_W-2:0], 1'b0};
        if (cnt_reg != '0) cnt_reg <= cnt_reg - 1'b1;
      end

      if (state_reg == ST_SHIFT && state_next == ST_DONE)
        compare_result_reg <= mode_result(mode_reg, final_gt, final_lt);

      if (abort) begin
        compare_result_reg <= 1'b0;
        if (error_count_reg != 8'hFF) error_count_reg <= error_count_reg + 8'd1;
      end
    end
  end

  assign compare_result = compare_result_reg;
  assign cmp_done       = (state_reg == ST_DONE) && !error;
  assign busy           = (state_reg != ST_IDLE);
  assign error_count    = error_count_reg;

endmodule

// File: tb/tb_compare_responder.sv
// Directed bench for compare_responder: expected results are queued at stimulus
// time from an arithmetic model and popped when cmp_done appears.
module tb_compare_responder;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] new_state;
  logic       hold;
  logic       error;
  logic [7:0] operand_a;
  logic [7:0] operand_b;
  logic       compare_result;
  logic       cmp_done;
  logic       busy;
  logic [7:0] error_count;

  int n_assert = 0;
  int n_fail   = 0;
  int exp_errs = 0;
  bit exp_q[$];

  compare_responder dut (
    .clk            (clk),
    .reset          (reset),
    .new_state      (new_state),
    .hold           (hold),
    .error          (error),
    .operand_a      (operand_a),
    .operand_b      (operand_b),
    .compare_result (compare_result),
    .cmp_done       (cmp_done),
    .busy           (busy),
    .error_count    (error_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit model(input logic [3:0] ns, input logic [7:0] a, input logic [7:0] b);
    case (ns[1:0])
      2'b00:   return a == b;
      2'b01:   return a > b;
      2'b10:   return a < b;
      default: return a != b;
    endcase
  endfunction

  // Launch a compare and wait (bounded) for cmp_done; operands are scrambled
  // after LOAD and hold is raised for hl cycles starting at cycle hs.
  task automatic do_compare(input logic [3:0] ns, input logic [7:0] a, input logic [7:0] b,
                            input int hs, input int hl, input int exp_lat);
    bit got = 0;
    bit exp_r = 0;
    int done_cyc = 0;
    new_state = ns;
    operand_a = a;
    operand_b = b;
    exp_q.push_back(model(ns, a, b));
    tick();
    for (int cyc = 1; cyc <= exp_lat + 4; cyc++) begin
      if (cyc <= exp_lat) check("busy_during", busy, 1);
      if (cmp_done) begin
        got = 1;
        done_cyc = cyc;
        check("done_cycle", cyc, exp_lat);
        if (exp_q.size() > 0) exp_r = exp_q.pop_front();
        check("result", compare_result, exp_r);
        break;
      end
      hold = (cyc >= hs) && (cyc < hs + hl);
      if (cyc >= 2) begin
        operand_a = 8'($urandom);
        operand_b = 8'($urandom);
      end
      tick();
    end
    hold = 1'b0;
    check("done_seen", got, 1);
    if (!got && exp_q.size() > 0) exp_r = exp_q.pop_front();
    $display("txn compare ns=%h a=%h b=%h result=%0d expected=%0d done_cycle=%0d",
             ns, a, b, compare_result, exp_r, done_cyc);
    tick();
    check("done_pulse_width", cmp_done, 0);
    check("busy_after", busy, 0);
    check("result_stable", compare_result, exp_r);
  endtask

  // Trigger then raise error during the 4th SHIFT cycle.
  task automatic do_abort(input logic [3:0] ns);
    new_state = ns;
    tick();
    for (int cyc = 1; cyc <= 5; cyc++) begin
      check("abort_no_done", cmp_done, 0);
      check("abort_busy", busy, 1);
      if (cyc == 5) error = 1'b1;
      tick();
    end
    error = 1'b0;
    if (exp_errs < 255) exp_errs++;
    check("abort_idle", busy, 0);
    check("abort_no_done_after", cmp_done, 0);
    check("abort_result", compare_result, 0);
    check("abort_count", error_count, exp_errs);
    $display("txn abort ns=%h error_count=%0d expected=%0d", ns, error_count, exp_errs);
  endtask

  logic [3:0] ns_tab [4] = '{4'h9, 4'hA, 4'hB, 4'hC};

  initial begin
    reset = 1'b1; hold = 1'b0; error = 1'b0;
    new_state = 4'h0; operand_a = 8'h00; operand_b = 8'h00;
    tick(); tick();
    reset = 1'b0;
    check("reset_result", compare_result, 1);
    check("reset_done", cmp_done, 0);
    check("reset_busy", busy, 0);
    check("reset_errcnt", error_count, 0);
    tick();
    check("idle_no_trigger", busy, 0);

    do_compare(4'h1, 8'h80, 8'h7F, 0, 0, 10);
    do_compare(4'h4, 8'h5A, 8'h5A, 0, 0, 10);
    do_compare(4'h6, 8'h5A, 8'h5B, 0, 0, 10);
    do_compare(4'h5, 8'h5A, 8'h5B, 0, 0, 10);
    do_compare(4'h7, 8'h03, 8'h03, 0, 0, 10);
    do_compare(4'h8, 8'h01, 8'h02, 0, 0, 10);
    do_compare(4'h2, 8'hFF, 8'h00, 0, 0, 10);
    do_compare(4'h3, 8'h10, 8'h11, 0, 0, 10);
    for (int i = 0; i < 4; i++) begin
      logic [7:0] ra;
      logic [7:0] rb;
      ra = 8'($urandom);
      rb = (i == 0) ? ra : 8'($urandom);
      do_compare(ns_tab[i], ra, rb, 0, 0, 10);
    end

    do_compare(4'hD, 8'hC3, 8'hC2, 4, 3, 13);

    do_abort(4'hA);

    // error in IDLE blocks the trigger and is not counted
    new_state = 4'hB;
    error = 1'b1;
    tick(); tick();
    check("idle_error_busy", busy, 0);
    check("idle_error_count", error_count, exp_errs);
    error = 1'b0;
    new_state = 4'hA;
    tick(); tick();
    check("unchanged_code_busy", busy, 0);
    new_state = 4'hF;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reserved_code_busy", busy, 0);
    end
    $display("txn no_trigger busy=%0d", busy);

    for (int k = 0; k < 299; k++)
      do_abort((k % 2 == 0) ? 4'hB : 4'hA);

    // reset mid-SHIFT
    new_state = 4'hC;
    tick();
    tick(); tick(); tick();
    check("pre_reset_busy", busy, 1);
    reset = 1'b1;
    new_state = 4'h0;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      check("rst_mid_no_done", cmp_done, 0);
      check("rst_mid_busy", busy, 0);
      tick();
    end
    check("rst_mid_result", compare_result, 1);
    check("rst_mid_errcnt", error_count, 0);
    $display("txn reset_mid_shift result=%0d error_count=%0d", compare_result, error_count);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/compare_responder.md
COMPARE_RESPONDER -- requirements
Module: compare_responder

Interface
REQ-001 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-002 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port new_state  input  4  state code from state_machine; [1:0] selects compare mode.
REQ-004 SHALL have port hold  input  1  state_machine hold; freezes comparison progress while high.
REQ-005 SHALL have port error  input  1  state_machine error; aborts the current comparison.
REQ-006 SHALL have port operand_a  input  8  unsigned first operand.
REQ-007 SHALL have port operand_b  input  8  unsigned second operand.
REQ-008 SHALL have port compare_result  output  1  registered result returned to state_machine.
REQ-009 SHALL have port cmp_done  output  1  one-cycle pulse marking a new compare_result.
REQ-010 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-011 SHALL have port error_count  output  8  saturating count of aborts.

Function
REQ-012 SHALL implement FSM states IDLE, LOAD, SHIFT, DONE.
REQ-013 SHALL register the last accepted new_state in prev_state; a trigger is new_state != prev_state, hold == 0, error == 0, new_state != 4'hF.
REQ-014 SHALL, in IDLE on trigger, capture new_state into prev_state and mode, and go to LOAD.
REQ-015 SHALL ignore code 4'hF (reserved): no trigger, prev_state unchanged.
REQ-016 SHALL, in LOAD, capture operand_a/operand_b into shift registers, clear gt/lt flags, set bit counter to 7, and go to SHIFT.
REQ-017 SHALL, in SHIFT, compare one bit per cycle MSB-first; the first differing bit sets gt (a=1) or lt (b=1), and later bits are ignored.
REQ-018 SHALL run exactly 8 SHIFT cycles (counter 7 down to 0) and then go to DONE; there is no early exit.
REQ-019 SHALL, while hold == 1 in LOAD or SHIFT, freeze the state, counter, and shift registers.
REQ-020 SHALL set the DONE result by mode: 00 EQ = !gt&&!lt; 01 GT = gt; 10 LT = lt; 11 NE = gt||lt.
REQ-021 SHALL load compare_result on the edge entering DONE, assert cmp_done for exactly the DONE cycle, then return to IDLE.
REQ-022 SHALL, with no hold, make the result visible 10 cycles after the trigger-sampling edge.
REQ-023 SHALL hold compare_result stable between DONE events.
REQ-024 SHALL, when error == 1 in LOAD, SHIFT, or DONE: return to IDLE, force compare_result to 0, suppress cmp_done, and increment error_count.
REQ-025 SHALL saturate error_count at 8'hFF.
REQ-026 SHALL give error priority over hold and over trigger in the same cycle.
REQ-027 SHALL leave error_count unchanged when error == 1 in IDLE.
REQ-028 SHALL ignore operand changes after LOAD until the next trigger.

Reset
REQ-029 SHALL, on reset (synchronous, active-high, dominant over all inputs), set: state IDLE, prev_state 4'h0, compare_result 1, cmp_done 0, busy 0, error_count 0, shift registers/flags/counter 0.
REQ-030 SHALL, on reset asserted mid-SHIFT, abandon the comparison without a cmp_done pulse and without counting an error.

Structure
REQ-031 SHALL place the FSM state encoding, mode codes (EQ/GT/LT/NE), reserved code 4'hF, and width constants (DATA_W = 8, STATE_W = 4) in shared package state_pkg.
REQ-032 SHALL implement the MSB-first bit comparator as sub-module serial_cmp (inputs bit_a, bit_b, clear, enable; outputs gt, lt).

Verification
REQ-033 SHALL verify: reset, then new_state 0->1 (mode GT), a=8'h80, b=8'h7F -> compare_result=1, cmp_done pulse 10 cycles after the trigger, busy high for 10 cycles.
REQ-034 SHALL verify: new_state 4'h4 (EQ), a=b=8'h5A -> compare_result=1; then new_state 4'h6 (LT), a=8'h5A, b=8'h5B -> compare_result=1 after 10 cycles.
REQ-035 SHALL verify: GT trigger with hold=1 for 3 cycles mid-SHIFT -> cmp_done at trigger+13, result is unchanged by the stall.
REQ-036 SHALL verify: error=1 in the 4th SHIFT cycle -> IDLE next cycle, compare_result=0, no cmp_done, error_count=1; 300 such aborts -> error_count=8'hFF.
REQ-037 SHALL verify: new_state 4'hF, or an unchanged new_state -> no trigger, busy stays 0.
REQ-038 SHALL verify: reset asserted mid-SHIFT -> compare_result=1, error_count=0, no cmp_done.
